// File: rtl/wrr_sched_pkg.sv
// Shared types and constants for the weighted round-robin burst scheduler.
package wrr_sched_pkg;

  // Default configuration: requester count and weight-field width.
  localparam int DEF_N  = 4;
  localparam int DEF_WW = 4;

  // Scheduler states: nobody owns the resource, or one requester holds it.
  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } sched_state_e;

  // A zero weight still grants a single beat.
  function automatic int unsigned eff_weight(input int unsigned w);
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority picker: first set request at or after i_ptr, wrapping mod N.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_req,
  input  logic [IW-1:0] i_ptr,
  output logic          o_found,
  output logic [IW-1:0] o_idx,
  output logic [N-1:0]  o_onehot
);

  // Scan requesters in priority order; keep the first one found.
  always_comb begin
    int unsigned j;
    j        = 0;
    o_found  = 1'b0;
    o_idx    = '0;
    o_onehot = '0;
    for (int unsigned k = 0; k < N; k++) begin
      j = (int'(i_ptr) + k) % N;
      if (!o_found && i_req[j]) begin
        o_found     = 1'b1;
        o_idx       = IW'(j);
        o_onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wrr_burst_scheduler.sv
// Weighted round-robin burst scheduler. A granted requester keeps the
// resource until its beat credit runs out, it signals last, or it drops req;
// priority then rotates to the requester after the previous owner.
// Optional feature macro: WRR_LOCK_EN (adds i_lock, which freezes credit).
module wrr_burst_scheduler
  import wrr_sched_pkg::*;
#(
  parameter int N  = DEF_N,
  parameter int WW = DEF_WW,
  parameter int IW = $clog2(N)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic [N-1:0]  i_req,
  input  logic          i_last,
  input  logic [N*WW-1:0] i_weight,
  output logic [N-1:0]  o_grant,
  output logic          o_grant_valid,
  output logic [IW-1:0] o_grant_id
`ifdef WRR_LOCK_EN
  ,
  input  logic          i_lock
`endif
);

  sched_state_e  r_state, w_state_nxt;
  logic [IW-1:0] r_ptr, w_ptr_nxt;
  logic [WW-1:0] r_credit, w_credit_nxt;
  logic [N-1:0]  r_grant, w_grant_nxt;
  logic [IW-1:0] r_grant_id, w_grant_id_nxt;

  logic          w_lock;
  logic          w_owner_req;
  logic          w_beat;
  logic          w_exhaust;
  logic          w_release;
  logic [IW-1:0] w_rel_ptr;
  logic [IW-1:0] w_pick_ptr;
  logic          w_found;
  logic [IW-1:0] w_idx;
  logic [N-1:0]  w_onehot;
  logic [WW-1:0] w_wt [N];
  logic [WW-1:0] w_load_credit;

`ifdef WRR_LOCK_EN
  assign w_lock = i_lock;
`else
  assign w_lock = 1'b0;
`endif

  // Unpack the flat weight bus into per-requester fields.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      w_wt[i] = i_weight[i*WW +: WW];
    end
  end

  // Beat/release decode for the current owner and the pointer used to arbitrate.
  always_comb begin
    w_owner_req = i_req[r_grant_id];
    w_beat      = (r_state == OWN) && w_owner_req;
    w_exhaust   = w_beat && !w_lock && (r_credit == WW'(1));
    w_release   = (r_state == OWN) &&
                  (!w_owner_req || (w_beat && i_last) || w_exhaust);
    w_rel_ptr   = (r_grant_id == IW'(N-1)) ? '0 : r_grant_id + 1'b1;
    // On a release the rotated pointer is used in the same cycle so the
    // handover has no idle gap.
    w_pick_ptr  = w_release ? w_rel_ptr : r_ptr;
  end

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .i_req    (i_req),
    .i_ptr    (w_pick_ptr),
    .o_found  (w_found),
    .o_idx    (w_idx),
    .o_onehot (w_onehot)
  );

  assign w_load_credit = WW'(eff_weight(int'(w_wt[w_idx])));

  // Next-state logic: start tenures, count beats, release and hand over.
  always_comb begin
    w_state_nxt    = r_state;
    w_ptr_nxt      = r_ptr;
    w_credit_nxt   = r_credit;
    w_grant_nxt    = r_grant;
    w_grant_id_nxt = r_grant_id;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          w_state_nxt    = OWN;
          w_grant_nxt    = w_onehot;
          w_grant_id_nxt = w_idx;
          w_credit_nxt   = w_load_credit;
        end
      end
      OWN: begin
        if (w_release) begin
          w_ptr_nxt = w_rel_ptr;
          if (w_found) begin
            w_grant_nxt    = w_onehot;
            w_grant_id_nxt = w_idx;
            w_credit_nxt   = w_load_credit;
          end else begin
            w_state_nxt  = IDLE;
            w_grant_nxt  = '0;
            w_credit_nxt = '0;
          end
        end else if (w_beat && !w_lock) begin
          w_credit_nxt = r_credit - 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_grant_nxt = '0;
      end
    endcase
  end

  // State and bookkeeping registers; reset overrides everything.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_credit   <= '0;
      r_grant    <= '0;
      r_grant_id <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_ptr      <= w_ptr_nxt;
      r_credit   <= w_credit_nxt;
      r_grant    <= w_grant_nxt;
      r_grant_id <= w_grant_id_nxt;
    end
  end

  assign o_grant       = r_grant;
  assign o_grant_valid = |r_grant;
  assign o_grant_id    = r_grant_id;

endmodule

// File: doc/wrr_burst_scheduler.md
# wrr_burst_scheduler

Weighted round-robin scheduler that shares one burst-oriented resource between N requesters. Grants are held for a multi-cycle tenure, bounded by a per-requester beat credit, an owner-signalled `last`, or the owner dropping `req`. Priority then rotates to the next requester. The block sits between requesters and the shared datapath and drives its select/enable from `grant`/`grant_id`.

## Interface
- `N`, 4: number of requesters (≥2).
- `WW`, 4: width of each weight field.
- `IW`, `$clog2(N)`: index width (derived).

- `clk`  in  1  clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N  per-requester request; held while the requester wants or uses the resource.
- `last`  in  1  owner marks the current beat as its final one.
- `weight`  in  N*WW  beat credit for requester i at bits `[i*WW +: WW]`; a value of 0 is treated as 1.
- `grant`  out  N  one-hot owner, registered.
- `grant_valid`  out  1  an owner exists (equals `|grant`).
- `grant_id`  out  IW  binary index of the owner; holds its last value when idle.

## Operation
- FSM has two states. IDLE: no owner. OWN: the owner holds the resource.
- Pointer `ptr` (IW bits): highest-priority index. Priority order is `ptr`, `ptr+1`, … wrapping mod N.
- **Arbitration:** winner = first set bit of `req` in rotating order from `ptr`. This is evaluated in IDLE, and in OWN on a release cycle.
- **Tenure start:** load `credit` ← effective weight of the winner, sampled at the grant edge. Set `grant`, `grant_id` and `grant_valid`.
- **Beat:** any OWN cycle with `req[grant_id]`=1. Each beat decrements `credit`.
- **Release conditions (OWN):**
  - `req[grant_id]`=0: release; the cycle is not a beat.
  - Beat with `last`=1: release.
  - Beat with `credit`==1: release (credit exhausted).
- **On release:**
  - `ptr` ← `grant_id+1` mod N.
  - Re-arbitrate in the same cycle using the new `ptr` and the current `req`.
  - If there is a winner, the new grant appears on the next edge with no idle gap, and `credit` is reloaded. Otherwise go to IDLE.
  - A sole remaining requester (including the previous owner) is re-granted.
- `last` is ignored outside a beat.
- `weight` changes mid-tenure do not affect the current `credit`.

## Timing
- **Reset values:** `grant`=0, `grant_valid`=0, `grant_id`=0, `ptr`=0, `credit`=0, state IDLE. Reset wins over every other event.
- **Reset mid-tenure:** outputs clear on the next edge and no release bookkeeping is performed.
- **Grant latency:** `req` sampled high at edge k (IDLE) gives `grant` valid after edge k, i.e. 1 cycle.
- **Handover:** on a release at edge k, the next owner's `grant` is valid after edge k. There is never a cycle with two bits set in `grant`.
- **Tenure length:** at most `max(weight,1)` beats. A weight of 15 with `WW`=4 gives 15 beats.
- **Simultaneous events:** `last`=1 together with `credit`==1 is one release. `req` drop together with `last` is a release with no beat.
- **Pointer:** `ptr` wraps from N-1 to 0.

## Configuration
- `WRR_LOCK_EN`
  - **Defined:** adds input port `lock` (1 bit). While `lock`=1 during a beat, `credit` does not decrement and credit exhaustion cannot release. `last` and `req` drop still release.
  - **Undefined:** no `lock` port, and behaviour is exactly as described above.

## Structure
- Package `wrr_sched_pkg` holds:
  - state enum `{IDLE, OWN}`;
  - default `N`/`WW` constants;
  - function `eff_weight` (maps 0 to 1).
- Sub-module `rr_pick`: purely combinational rotating-priority picker.
  - Inputs: `req[N]`, `ptr[IW]`.
  - Outputs: `found`, `idx[IW]`, `onehot[N]`.
  - Instantiated once.

## Test plan
- **Reset:** hold `rst`=1 for 2 cycles with `req`=4'b1111 → `grant`=0, `grant_valid`=0, `grant_id`=0 throughout. `req` stays 4'b1111 and `rst` is released with all weights 3 → the first grant after the release edge is 4'b0001.
- **Credit rotation:** weights all 2, `req`=4'b0110 held → `grant` 4'b0010 for 2 cycles, then 4'b0100 for 2 cycles, then 4'b0010 again, with no idle cycles between tenures.
- **Early release on `last`:** weight[0]=5, `req`=4'b0001, `last` pulsed on the 2nd beat → 2-cycle tenure, then 4'b0001 re-granted (sole requester) with `credit` reloaded to 5.
- **Req drop and weight 0:** weight[3]=0, `req`=4'b1000 → 1-cycle tenure. Separately, an owner drops `req` mid-tenure → `grant` clears on the next edge, and `ptr` = owner+1.
- **Wrap-around:** `ptr`=3 with `req`=4'b1001 → 4'b1000 granted first, then 4'b0001.
- **`WRR_LOCK_EN` build:** weight[1]=1, `lock`=1, `req`=4'b0010 for 6 cycles → `grant` held 6 cycles. `lock` is deasserted on the 7th cycle with `req`=4'b0010 still held → release after that beat.
